btb_update_ctrl: RTL and testbench

- Resolution-side partner of the branch target buffer.
- Carries each fetch-time BTB prediction (pc, direction, target, 2-bit counter) alongside the instruction through ID into EX.
- Compares the prediction against the resolved branch outcome and drives the BTB write-port signals.
- Issues a one-cycle redirect/flush to the fetch PC mux on a wrong direction or wrong target.

---
 rtl/btb_update_ctrl_pkg.sv | 33 +++
 rtl/btb_update_ctrl_if.sv | 42 ++++
 rtl/btb_update_ctrl_meta_pipe.sv | 56 +++++
 rtl/btb_update_ctrl.sv | 151 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/btb_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btb_update_ctrl_pkg
//  Description : Shared types for the BTB resolution-side update controller:
//                per-instruction prediction metadata and controller states.
//  Revision    : 1.0 - initial release
// ============================================================================
package btb_update_ctrl_pkg;

    // Prediction metadata carried with an instruction from fetch to EX.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [1:0]  pred_rdata;
    } btb_meta_t;

    // Controller state: normal operation, or the single squash cycle.
    typedef enum logic [0:0] {
        BTBU_RUN   = 1'b0,
        BTBU_FLUSH = 1'b1
    } btb_upd_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Sequential successor of a branch (32-bit wraparound).
    function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_update_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : btb_update_ctrl_if
//  Description : Fetch capture, EX resolution and BTB write / redirect bus of
//                the BTB update controller. slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface btb_update_ctrl_if;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic [1:0]  if_pred_rdata;
    logic        ex_is_br;
    logic        ex_br_en;
    logic [31:0] ex_target;
    logic        btb_write_bp;
    logic        btb_mispredict;
    logic        btb_wrong_pc;
    logic [31:0] pc_address_write;
    logic [31:0] branch_target_address_real;
    logic [1:0]  btb_rdata_ret;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;

    modport master (
        output stall, if_valid, if_pc, if_pred_taken, if_pred_target, if_pred_rdata,
        output ex_is_br, ex_br_en, ex_target,
        input  btb_write_bp, btb_mispredict, btb_wrong_pc, pc_address_write,
        input  branch_target_address_real, btb_rdata_ret, redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  stall, if_valid, if_pc, if_pred_taken, if_pred_target, if_pred_rdata,
        input  ex_is_br, ex_br_en, ex_target,
        output btb_write_bp, btb_mispredict, btb_wrong_pc, pc_address_write,
        output branch_target_address_real, btb_rdata_ret, redirect_valid, redirect_pc, flush
    );
endinterface
`default_nettype wire

// File: rtl/btb_update_ctrl_meta_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : btb_meta_pipe
//  Description : DEPTH-deep shift register of prediction metadata. Holds on
//                stall; a flush clears every valid bit, including the entry
//                that would otherwise be captured this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_meta_pipe
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      stall_i,
    input  wire logic      flush_i,
    input  wire btb_meta_t meta_i,
    output btb_meta_t      meta_o
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        btb_meta_t slot_q;
        btb_meta_t slot_d;
        btb_meta_t src_w;

        if (i == 0) begin : g_head
            assign src_w = meta_i;
        end else begin : g_body
            assign src_w = g_slot[i-1].slot_q;
        end

        // Next slot contents: squash on flush, hold on stall, else shift.
        always_comb begin
            slot_d = slot_q;
            if (flush_i) begin
                slot_d.valid = 1'b0;
            end else if (!stall_i) begin
                slot_d = src_w;
            end
        end

        // Slot register.
        always_ff @(posedge clk) begin
            if (!rst) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end
    end

    assign meta_o = g_slot[DEPTH-1].slot_q;

endmodule
`default_nettype wire

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : btb_update_ctrl
//  Description : Carries fetch-time BTB predictions to EX, compares them with
//                the resolved outcome, drives the BTB write port for one cycle
//                and issues a one-cycle redirect/flush on a misprediction.
//                Optional macro BTB_UPDATE_PERF_CNT_EN adds perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  wire logic         clk,
    input  wire logic         rst,
    btb_update_ctrl_if.slave  bus
`ifdef BTB_UPDATE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_br_cnt,
    output logic [31:0]       perf_dir_miss_cnt,
    output logic [31:0]       perf_tgt_miss_cnt
`endif
);

    btb_upd_state_t state_q;
    btb_upd_state_t state_d;
    btb_meta_t      fetch_w;
    btb_meta_t      ex_meta_w;
    logic           in_flush_w;
    logic           resolve_w;
    logic           mis_w;
    logic           wpc_w;

    logic           write_bp_q;
    logic           mispredict_q;
    logic           wrong_pc_q;
    logic [31:0]    pc_address_q;
    logic [31:0]    target_real_q;
    logic [1:0]     rdata_ret_q;
    logic [31:0]    redirect_pc_q;

    assign fetch_w = '{valid:       bus.if_valid,
                       pc:          bus.if_pc,
                       pred_taken:  bus.if_pred_taken,
                       pred_target: bus.if_pred_target,
                       pred_rdata:  bus.if_pred_rdata};

    assign in_flush_w = (state_q == BTBU_FLUSH);

    btb_meta_pipe #(.DEPTH(DEPTH)) u_meta_pipe (
        .clk     (clk),
        .rst     (rst),
        .stall_i (bus.stall),
        .flush_i (in_flush_w),
        .meta_i  (fetch_w),
        .meta_o  (ex_meta_w)
    );

    // The slot reaching EX during a flush cycle is wrong-path, so never resolve it.
    assign resolve_w = !in_flush_w && !bus.stall && ex_meta_w.valid && bus.ex_is_br;
    assign mis_w     = ex_meta_w.pred_taken ^ bus.ex_br_en;
    assign wpc_w     = bus.ex_br_en &
                       (!ex_meta_w.pred_taken || (ex_meta_w.pred_target != bus.ex_target));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BTBU_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a wrong resolution opens exactly one flush cycle.
    always_comb begin
        state_d = BTBU_RUN;
        if (state_q == BTBU_RUN && resolve_w && (mis_w || wpc_w)) begin
            state_d = BTBU_FLUSH;
        end
    end

    // FSM outputs: redirect and flush coincide with the registered update.
    always_comb begin
        bus.redirect_valid = in_flush_w;
        bus.flush          = in_flush_w;
    end

    // Update port registers: strobes pulse for one cycle, data holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_bp_q    <= 1'b0;
            mispredict_q  <= 1'b0;
            wrong_pc_q    <= 1'b0;
            pc_address_q  <= RESET_PC;
            target_real_q <= '0;
            rdata_ret_q   <= '0;
            redirect_pc_q <= RESET_PC;
        end else begin
            write_bp_q   <= resolve_w;
            mispredict_q <= resolve_w & mis_w;
            wrong_pc_q   <= resolve_w & wpc_w;
            if (resolve_w) begin
                pc_address_q  <= ex_meta_w.pc;
                target_real_q <= bus.ex_target;
                rdata_ret_q   <= ex_meta_w.pred_rdata;
                if (mis_w || wpc_w) begin
                    redirect_pc_q <= bus.ex_br_en ? bus.ex_target
                                                  : fallthrough_pc(ex_meta_w.pc);
                end
            end
        end
    end

    assign bus.btb_write_bp               = write_bp_q;
    assign bus.btb_mispredict             = mispredict_q;
    assign bus.btb_wrong_pc               = wrong_pc_q;
    assign bus.pc_address_write           = pc_address_q;
    assign bus.branch_target_address_real = target_real_q;
    assign bus.btb_rdata_ret              = rdata_ret_q;
    assign bus.redirect_pc                = redirect_pc_q;

`ifdef BTB_UPDATE_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] dir_miss_cnt_q;
    logic [31:0] tgt_miss_cnt_q;

    // Perf counters step on the same edge that registers the update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            br_cnt_q       <= '0;
            dir_miss_cnt_q <= '0;
            tgt_miss_cnt_q <= '0;
        end else if (resolve_w) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (mis_w) begin
                dir_miss_cnt_q <= dir_miss_cnt_q + 32'd1;
            end else if (wpc_w) begin
                tgt_miss_cnt_q <= tgt_miss_cnt_q + 32'd1;
            end
        end
    end

    assign perf_br_cnt       = br_cnt_q;
    assign perf_dir_miss_cnt = dir_miss_cnt_q;
    assign perf_tgt_miss_cnt = tgt_miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btb_update_ctrl
//  Description : Self-checking bench for btb_update_ctrl: directed scenarios
//                followed by random traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0060;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    btb_update_ctrl_if bus ();

`ifdef BTB_UPDATE_PERF_CNT_EN
    logic [31:0] perf_br_cnt, perf_dir_miss_cnt, perf_tgt_miss_cnt;
`endif

    btb_update_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef BTB_UPDATE_PERF_CNT_EN
        ,
        .perf_br_cnt       (perf_br_cnt),
        .perf_dir_miss_cnt (perf_dir_miss_cnt),
        .perf_tgt_miss_cnt (perf_tgt_miss_cnt)
`endif
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        pt;
        bit [31:0] tgt;
        bit [1:0]  rd;
    } ent_t;

    ent_t      pipe[$];          // front = youngest, back = instruction in EX
    bit        flushing;         // current cycle is a squash cycle
    bit        e_wbp, e_mis, e_wpc, e_redir;
    bit [31:0] e_paw, e_bta, e_rpc;
    bit [1:0]  e_rd;
    int        n_br, n_dir, n_tgt, n_wbp;

    task automatic model_reset();
        ent_t z;
        z = '{v: 0, pc: 0, pt: 0, tgt: 0, rd: 0};
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
        flushing = 0; e_wbp = 0; e_mis = 0; e_wpc = 0; e_redir = 0;
        e_paw = RESET_PC; e_rpc = RESET_PC; e_bta = 0; e_rd = 0;
        n_br = 0; n_dir = 0; n_tgt = 0;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit r, input bit s, input bit v, input bit [31:0] pc,
                        input bit pt, input bit [31:0] ptg, input bit [1:0] rd,
                        input bit isbr, input bit bren, input bit [31:0] ext);
        ent_t      old, nw;
        bit        res, mis, wpc;
        @(negedge clk);
        rst = r; bus.stall = s; bus.if_valid = v; bus.if_pc = pc;
        bus.if_pred_taken = pt; bus.if_pred_target = ptg; bus.if_pred_rdata = rd;
        bus.ex_is_br = isbr; bus.ex_br_en = bren; bus.ex_target = ext;
        if (!r) begin
            model_reset();
        end else begin
            old = pipe[$];
            res = !flushing && !s && old.v && isbr;
            mis = old.pt != bren;
            wpc = bren && (!old.pt || old.tgt != ext);
            e_wbp = res; e_mis = res && mis; e_wpc = res && wpc;
            if (res) begin
                n_br++;
                if (mis) n_dir++;
                else if (wpc) n_tgt++;
                e_paw = old.pc; e_bta = ext; e_rd = old.rd;
                if (mis || wpc) e_rpc = bren ? ext : old.pc + 32'd4;
            end
            if (flushing) begin
                foreach (pipe[i]) pipe[i].v = 0;
            end else if (!s) begin
                nw = '{v: v, pc: pc, pt: pt, tgt: ptg, rd: rd};
                pipe.push_front(nw);
                void'(pipe.pop_back());
            end
            flushing = res && (mis || wpc);
            e_redir  = flushing;
        end
        @(posedge clk);
        #1;
        if (bus.btb_write_bp === 1'b1) n_wbp++;
        check_val("write_bp",   {31'd0, bus.btb_write_bp},   {31'd0, e_wbp});
        check_val("mispredict", {31'd0, bus.btb_mispredict}, {31'd0, e_mis});
        check_val("wrong_pc",   {31'd0, bus.btb_wrong_pc},   {31'd0, e_wpc});
        check_val("redirect_v", {31'd0, bus.redirect_valid}, {31'd0, e_redir});
        check_val("flush",      {31'd0, bus.flush},          {31'd0, e_redir});
        check_val("pc_addr_wr", bus.pc_address_write,        e_paw);
        check_val("tgt_real",   bus.branch_target_address_real, e_bta);
        check_val("rdata_ret",  {30'd0, bus.btb_rdata_ret},  {30'd0, e_rd});
        check_val("redirect_pc", bus.redirect_pc,            e_rpc);
`ifdef BTB_UPDATE_PERF_CNT_EN
        check_val("perf_br",  perf_br_cnt,       n_br);
        check_val("perf_dir", perf_dir_miss_cnt, n_dir);
        check_val("perf_tgt", perf_tgt_miss_cnt, n_tgt);
`endif
    endtask

    // Idle fetch / no branch in EX.
    task automatic idle(input bit s);
        step(1, s, 0, 32'h0, 0, 32'h0, 2'b00, 0, 0, 32'h0);
    endtask

    initial begin
        int wbp_before;
        bit [31:0] tg;
        model_reset();
        bus.stall = 0; bus.if_valid = 0; bus.if_pc = 0; bus.if_pred_taken = 0;
        bus.if_pred_target = 0; bus.if_pred_rdata = 0;
        bus.ex_is_br = 0; bus.ex_br_en = 0; bus.ex_target = 0;

        // Reset for two cycles.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Correct not-taken prediction.
        step(1, 0, 1, 32'h100, 0, 32'h0, 2'b01, 0, 0, 32'h0);
        idle(0);
        step(1, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        idle(0);

        // Predicted taken, actually not taken; younger fetch is squashed.
        step(1, 0, 1, 32'h200, 1, 32'h240, 2'b10, 0, 0, 32'h0);
        step(1, 0, 1, 32'h204, 0, 32'h0,   2'b00, 0, 0, 32'h0);
        step(1, 0, 1, 32'h208, 0, 32'h0,   2'b00, 1, 0, 32'h0);
        step(1, 0, 1, 32'h20C, 0, 32'h0,   2'b00, 1, 0, 32'h0);
        step(1, 0, 0, 32'h0,   0, 32'h0,   2'b00, 1, 1, 32'h999);
        step(1, 0, 0, 32'h0,   0, 32'h0,   2'b00, 1, 1, 32'h999);

        // Taken with wrong target.
        step(1, 0, 1, 32'h300, 1, 32'h340, 2'b11, 0, 0, 32'h0);
        idle(0);
        step(1, 0, 0, 32'h0, 0, 0, 0, 1, 1, 32'h380);
        idle(0);
        idle(0);

        // Branch held in EX by a 3-cycle stall: exactly one update.
        step(1, 0, 1, 32'h400, 0, 32'h0, 2'b01, 0, 0, 32'h0);
        idle(0);
        wbp_before = n_wbp;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        idle(0);
        idle(0);
        check_val("stall_one_pulse", n_wbp - wbp_before, 32'd1);

        // Fall-through wraparound.
        step(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h10, 2'b10, 0, 0, 32'h0);
        idle(0);
        step(1, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        idle(0);

        // Reset in the middle of a flush.
        step(1, 0, 1, 32'h500, 1, 32'h540, 2'b10, 0, 0, 32'h0);
        idle(0);
        step(1, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 32'h600, 0, 32'h0, 2'b00, 1, 0, 32'h0);
        idle(0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            tg = 32'h1000 + ($urandom_range(0, 3) << 4);
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 255), 2'b00},
                 1'($urandom_range(0, 1)),
                 tg,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 70),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? tg : 32'h1000 + ($urandom_range(0, 3) << 4));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
